pipeline_rr_merge: RTL

Merges `NUM_IN` independent valid/ready element streams into one registered pipeline stage using round-robin arbitration. It is the many-to-one counterpart of the branch/fan-out stages and shares one downstream consumer fairly between requesters. Each output beat carries the index of the input it came from, so a downstream branch or demux can route responses back.

---
 rtl/pipeline_rr_merge_pkg.sv | 30 +++
 rtl/pipeline_rr_merge_arbiter.sv | 39 +++
 rtl/pipeline_rr_merge.sv | 75 +++++++
 3 files changed

// File: rtl/pipeline_rr_merge_pkg.sv
// Shared arbitration helpers: a rotate-scan priority search reusable by any
// round-robin arbiter up to RR_MAX_REQ requesters.
package pipeline_rr_merge_pkg;

  localparam int unsigned RR_MAX_REQ = 32;

  // Scans req starting at 'start', wrapping at numReq; reports the first set bit.
  function automatic void rrScan(
    input  logic [RR_MAX_REQ-1:0] req,
    input  int unsigned           numReq,
    input  int unsigned           start,
    output int unsigned           grant,
    output logic                  anyValid
  );
    logic [RR_MAX_REQ-1:0] shifted;
    int unsigned           pos;
    grant    = 0;
    anyValid = 1'b0;
    for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
      pos = start + k;
      if (pos >= numReq) pos = pos - numReq;
      shifted = req >> pos;
      if ((k < numReq) && !anyValid && shifted[0]) begin
        grant    = pos;
        anyValid = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/pipeline_rr_merge_arbiter.sv
// Round-robin arbiter: combinational grant from the current pointer, pointer
// moves one past the winner whenever the parent completes a handshake.
module rr_arbiter import pipeline_rr_merge_pkg::*; #(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [NUM_IN-1:0] req_i,
  input  logic              advance_i,
  output logic [IDX_W-1:0]  grant_o,
  output logic              anyValid_o
);

  logic [IDX_W-1:0]      ptr_q;
  logic [IDX_W-1:0]      ptr_d;
  logic [RR_MAX_REQ-1:0] reqWide;
  int unsigned           grantInt;

  always_comb begin
    reqWide = RR_MAX_REQ'(req_i);
    rrScan(reqWide, NUM_IN, 32'(ptr_q), grantInt, anyValid_o);
    grant_o = IDX_W'(grantInt);
  end

  // Wrap explicitly so non-power-of-two sizes never visit an unused index.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (grant_o == IDX_W'(NUM_IN - 1)) ? '0 : grant_o + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pipeline_rr_merge.sv
// Many-to-one registered merge stage: round-robin picks one valid requester per
// cycle and loads it into a single output register tagged with its source index.
module pipeline_rr_merge import pipeline_rr_merge_pkg::*; #(
  parameter  int NUM_IN     = 4,
  parameter  int ELEM_WIDTH = 8,
  localparam int IDX_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                             clk_i,
  input  logic                             srst_i,
  input  logic [NUM_IN-1:0][ELEM_WIDTH-1:0] elem_in_i,
  input  logic [NUM_IN-1:0]                elem_in_valid_i,
  output logic [NUM_IN-1:0]                elem_in_ready_o,
  output logic [ELEM_WIDTH-1:0]            elem_out_o,
  output logic [IDX_W-1:0]                 elem_out_idx_o,
  output logic                             elem_out_valid_o,
  input  logic                             elem_out_ready_i
);

  logic [IDX_W-1:0]      grant;
  logic                  anyValid;
  logic                  accept;
  logic                  handshake;
  logic [ELEM_WIDTH-1:0] outData_q, outData_d;
  logic [IDX_W-1:0]      outIdx_q, outIdx_d;
  logic                  outValid_q, outValid_d;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_arbiter (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .req_i      (elem_in_valid_i),
    .advance_i  (handshake),
    .grant_o    (grant),
    .anyValid_o (anyValid)
  );

  // Fill whenever empty or draining this cycle; reset blocks any new handshake.
  always_comb begin
    accept          = ~outValid_q | elem_out_ready_i;
    handshake       = accept & anyValid & ~srst_i;
    elem_in_ready_o = handshake ? (NUM_IN'(1) << grant) : '0;
  end

  always_comb begin
    outData_d  = outData_q;
    outIdx_d   = outIdx_q;
    outValid_d = outValid_q;
    if (handshake) begin
      outData_d  = elem_in_i[grant];
      outIdx_d   = grant;
      outValid_d = 1'b1;
    end else if (elem_out_ready_i) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      outData_q  <= '0;
      outIdx_q   <= '0;
      outValid_q <= 1'b0;
    end else begin
      outData_q  <= outData_d;
      outIdx_q   <= outIdx_d;
      outValid_q <= outValid_d;
    end
  end

  assign elem_out_o       = outData_q;
  assign elem_out_idx_o   = outIdx_q;
  assign elem_out_valid_o = outValid_q;

endmodule
